// File: rtl/hazard_pkg.sv
// Shared types and constants for the multi-cycle hazard/forwarding controller.
// Used by hazard_unit_mc and hazard_fwd_sel.
package hazard_pkg;

  typedef enum logic [1:0] {
    FWD_RF = 2'b00,
    FWD_W  = 2'b01,
    FWD_M  = 2'b10
  } fwd_sel_e;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } mc_state_e;

  localparam logic [1:0] RESULT_LOAD = 2'b01;

  // Width of the multi-cycle down-counter; never narrower than one bit.
  function automatic int mc_count_width(input int mc_lat);
    return (mc_lat > 2) ? $clog2(mc_lat) : 1;
  endfunction

endpackage

// File: rtl/hazard_fwd_sel.sv
// Per-operand forwarding select for the E stage: M beats W, and x0 is never forwarded.
module hazard_fwd_sel
  import hazard_pkg::*;
#(
  parameter int REG_AW = 5
) (
  input  logic [REG_AW-1:0] rs,
  input  logic [REG_AW-1:0] rd_m,
  input  logic              reg_write_m,
  input  logic [REG_AW-1:0] rd_w,
  input  logic              reg_write_w,
  output logic [1:0]        fwd
);

  fwd_sel_e sel;

  always_comb begin
    sel = FWD_RF;
    if (rs != '0) begin
      if (reg_write_m && (rd_m == rs)) begin
        sel = FWD_M;
      end else if (reg_write_w && (rd_w == rs)) begin
        sel = FWD_W;
      end
    end
  end

  assign fwd = sel;

endmodule

// File: rtl/hazard_unit_mc.sv
// Hazard/forwarding controller for the 5-stage pipeline with multi-cycle Execute ops.
// Optional perf counters are built when HAZARD_PERF_EN is defined.
module hazard_unit_mc
  import hazard_pkg::*;
#(
  parameter int REG_AW = 5,
  parameter int MC_LAT = 4,
  parameter int PERF_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [REG_AW-1:0] Rs1_D,
  input  logic [REG_AW-1:0] Rs2_D,
  input  logic [REG_AW-1:0] Rs1_E,
  input  logic [REG_AW-1:0] Rs2_E,
  input  logic [REG_AW-1:0] Rd_E,
  input  logic [1:0]        ResultSrc_E,
  input  logic              PCSrc_E,
  input  logic              McStart_E,
  input  logic [REG_AW-1:0] Rd_M,
  input  logic [REG_AW-1:0] Rd_W,
  input  logic              RegWrite_M,
  input  logic              RegWrite_W,
  input  logic              TrapFlush,
  output logic [1:0]        ForwardA_E,
  output logic [1:0]        ForwardB_E,
  output logic              Stall_F,
  output logic              Stall_D,
  output logic              Stall_E,
  output logic              Flush_D,
  output logic              Flush_E,
  output logic              Flush_M,
`ifdef HAZARD_PERF_EN
  output logic [PERF_W-1:0] PerfLwStall,
  output logic [PERF_W-1:0] PerfMcStall,
  output logic [PERF_W-1:0] PerfFlush,
`endif
  output logic              McBusy
);

  localparam int CNT_W = mc_count_width(MC_LAT);
  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'((MC_LAT > 1) ? (MC_LAT - 2) : 0);
  localparam bit MC_ENABLED = (MC_LAT > 1);

  // ---------------------------------------------------------------
  // Forwarding: one compare slice per E-stage operand
  // ---------------------------------------------------------------
  logic [REG_AW-1:0] rs_e   [2];
  logic [1:0]        fwd_e  [2];

  assign rs_e[0] = Rs1_E;
  assign rs_e[1] = Rs2_E;

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_fwd
      hazard_fwd_sel #(
        .REG_AW(REG_AW)
      ) u_fwd_sel (
        .rs          (rs_e[gi]),
        .rd_m        (Rd_M),
        .reg_write_m (RegWrite_M),
        .rd_w        (Rd_W),
        .reg_write_w (RegWrite_W),
        .fwd         (fwd_e[gi])
      );
    end
  endgenerate

  assign ForwardA_E = fwd_e[0];
  assign ForwardB_E = fwd_e[1];

  // ---------------------------------------------------------------
  // Load-use detection
  // ---------------------------------------------------------------
  logic lw_stall;

  assign lw_stall = (ResultSrc_E == RESULT_LOAD) && (Rd_E != '0) &&
                    ((Rs1_D == Rd_E) || (Rs2_D == Rd_E));

  // ---------------------------------------------------------------
  // Multi-cycle occupancy FSM
  // ---------------------------------------------------------------
  mc_state_e        state_reg, state_next;
  logic [CNT_W-1:0] count_reg, count_next;
  logic             mc_start_ok;
  logic             mc_stall;

  // A redirect or trap in the start cycle means the op is squashed, not run.
  assign mc_start_ok = MC_ENABLED && McStart_E && !PCSrc_E && !TrapFlush;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg <= IDLE;
      count_reg <= '0;
    end else begin
      state_reg <= state_next;
      count_reg <= count_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    count_next = count_reg;
    if (TrapFlush) begin
      state_next = IDLE;
      count_next = '0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (mc_start_ok) begin
            state_next = BUSY;
            count_next = CNT_INIT;
          end
        end
        BUSY: begin
          if (count_reg == '0) begin
            state_next = IDLE;
          end else begin
            count_next = count_reg - 1'b1;
          end
        end
        default: begin
          state_next = IDLE;
          count_next = '0;
        end
      endcase
    end
  end

  always_comb begin
    mc_stall = 1'b0;
    McBusy   = 1'b0;
    case (state_reg)
      IDLE:    mc_stall = mc_start_ok;
      BUSY: begin
        mc_stall = 1'b1;
        McBusy   = 1'b1;
      end
      default: mc_stall = 1'b0;
    endcase
  end

  // ---------------------------------------------------------------
  // Stage enables / clears; trap overrides everything
  // ---------------------------------------------------------------
  logic redirect;

  assign redirect = PCSrc_E && !mc_stall;

  always_comb begin
    Stall_F = 1'b0;
    Stall_D = 1'b0;
    Stall_E = 1'b0;
    Flush_D = 1'b0;
    Flush_E = 1'b0;
    Flush_M = 1'b0;
    if (TrapFlush) begin
      Flush_D = 1'b1;
      Flush_E = 1'b1;
      Flush_M = 1'b1;
    end else begin
      Stall_F = lw_stall || mc_stall;
      Stall_D = lw_stall || mc_stall;
      Stall_E = mc_stall;
      Flush_M = mc_stall;
      Flush_E = lw_stall || redirect;
      Flush_D = redirect;
    end
  end

`ifdef HAZARD_PERF_EN
  // ---------------------------------------------------------------
  // Saturating event counters: 0 load-use, 1 multi-cycle, 2 control flush
  // ---------------------------------------------------------------
  logic [2:0]        perf_event;
  logic [PERF_W-1:0] perf_reg [3];

  assign perf_event[0] = lw_stall && !TrapFlush;
  assign perf_event[1] = mc_stall && !TrapFlush;
  assign perf_event[2] = TrapFlush || redirect;

  generate
    for (genvar gi = 0; gi < 3; gi++) begin : g_perf
      always_ff @(posedge clk) begin
        if (!rst_n) begin
          perf_reg[gi] <= '0;
        end else if (perf_event[gi] && (perf_reg[gi] != '1)) begin
          perf_reg[gi] <= perf_reg[gi] + 1'b1;
        end
      end
    end
  endgenerate

  assign PerfLwStall = perf_reg[0];
  assign PerfMcStall = perf_reg[1];
  assign PerfFlush   = perf_reg[2];
`endif

`ifndef SYNTHESIS
  // Redirect and multi-cycle start in the same cycle: the start is dropped.
  always_ff @(posedge clk) begin
    if (rst_n) begin
      assert (!(PCSrc_E && McStart_E))
        else $warning("hazard_unit_mc: McStart_E ignored because PCSrc_E is set");
    end
  end
`endif

endmodule

// File: tb/tb_hazard_unit_mc.sv
// Directed bench for hazard_unit_mc (MC_LAT=4); optional perf ports under HAZARD_PERF_EN.
module tb_hazard_unit_mc;

  logic       clk;
  logic       rst_n;
  logic [4:0] Rs1_D, Rs2_D, Rs1_E, Rs2_E, Rd_E, Rd_M, Rd_W;
  logic [1:0] ResultSrc_E;
  logic       PCSrc_E, McStart_E, RegWrite_M, RegWrite_W, TrapFlush;
  logic [1:0] ForwardA_E, ForwardB_E;
  logic       Stall_F, Stall_D, Stall_E, Flush_D, Flush_E, Flush_M, McBusy;
`ifdef HAZARD_PERF_EN
  logic [31:0] PerfLwStall, PerfMcStall, PerfFlush;
`endif

  int tests_run = 0;
  int tests_failed = 0;

  hazard_unit_mc #(
    .REG_AW(5),
    .MC_LAT(4),
    .PERF_W(32)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .Rs1_D       (Rs1_D),
    .Rs2_D       (Rs2_D),
    .Rs1_E       (Rs1_E),
    .Rs2_E       (Rs2_E),
    .Rd_E        (Rd_E),
    .ResultSrc_E (ResultSrc_E),
    .PCSrc_E     (PCSrc_E),
    .McStart_E   (McStart_E),
    .Rd_M        (Rd_M),
    .Rd_W        (Rd_W),
    .RegWrite_M  (RegWrite_M),
    .RegWrite_W  (RegWrite_W),
    .TrapFlush   (TrapFlush),
    .ForwardA_E  (ForwardA_E),
    .ForwardB_E  (ForwardB_E),
    .Stall_F     (Stall_F),
    .Stall_D     (Stall_D),
    .Stall_E     (Stall_E),
    .Flush_D     (Flush_D),
    .Flush_E     (Flush_E),
    .Flush_M     (Flush_M),
`ifdef HAZARD_PERF_EN
    .PerfLwStall (PerfLwStall),
    .PerfMcStall (PerfMcStall),
    .PerfFlush   (PerfFlush),
`endif
    .McBusy      (McBusy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Packed view: {FwdA[1:0], FwdB[1:0], Stall_F, Stall_D, Stall_E, Flush_D, Flush_E, Flush_M, McBusy}
  function automatic logic [10:0] obs_vec();
    return {ForwardA_E, ForwardB_E, Stall_F, Stall_D, Stall_E,
            Flush_D, Flush_E, Flush_M, McBusy};
  endfunction

  task automatic check(input string tag, input logic [10:0] exp);
    logic [10:0] obs;
    #1;
    obs = obs_vec();
    tests_run++;
    assert (obs === exp)
      $display("[TB] %-14s obs=%b exp=%b ok", tag, obs, exp);
    else begin
      tests_failed++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    Rs1_D = '0; Rs2_D = '0; Rs1_E = '0; Rs2_E = '0; Rd_E = '0;
    Rd_M = '0; Rd_W = '0; ResultSrc_E = 2'b00;
    PCSrc_E = 1'b0; McStart_E = 1'b0;
    RegWrite_M = 1'b0; RegWrite_W = 1'b0; TrapFlush = 1'b0;
  endtask

  initial begin
    clear_inputs();
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    check("reset", 11'b00_00_0000000);
`ifdef HAZARD_PERF_EN
    tests_run++;
    assert (PerfMcStall === 32'd0)
    else begin
      tests_failed++;
      $error("FAIL perf_reset observed=%0d expected=0", PerfMcStall);
    end
`endif

    // Forwarding
    Rd_M = 5'd5; RegWrite_M = 1'b1; Rs1_E = 5'd5;
    check("fwdA_M", 11'b10_00_0000000);
    Rd_W = 5'd5; RegWrite_W = 1'b1;
    check("fwdA_M_over_W", 11'b10_00_0000000);
    RegWrite_M = 1'b0;
    check("fwdA_W", 11'b01_00_0000000);
    Rs2_E = 5'd5; Rd_M = 5'd9; RegWrite_M = 1'b1;
    check("fwdAB_W", 11'b01_01_0000000);
    Rs1_E = 5'd0; Rs2_E = 5'd0; Rd_M = 5'd0; Rd_W = 5'd0;
    check("fwd_x0", 11'b00_00_0000000);
    clear_inputs();

    // Load-use
    tick();
    ResultSrc_E = 2'b01; Rd_E = 5'd7; Rs2_D = 5'd7;
    check("lw_stall", 11'b00_00_1100100);
    tick();
    ResultSrc_E = 2'b00; Rd_E = 5'd0; Rs2_D = 5'd0;
    check("lw_release", 11'b00_00_0000000);
    ResultSrc_E = 2'b01; Rd_E = 5'd0; Rs1_D = 5'd0;
    check("lw_x0", 11'b00_00_0000000);
    clear_inputs();

    // Multi-cycle op, MC_LAT=4
    tick();
    McStart_E = 1'b1;
    check("mc_start", 11'b00_00_1110010);
    tick();
    McStart_E = 1'b0;
    check("mc_busy1", 11'b00_00_1110011);
    tick();
    check("mc_busy2", 11'b00_00_1110011);
    tick();
    check("mc_busy3", 11'b00_00_1110011);
    tick();
    check("mc_done", 11'b00_00_0000000);

    // Trap during second BUSY cycle
    McStart_E = 1'b1;
    check("trap_start", 11'b00_00_1110010);
    tick();
    McStart_E = 1'b0;
    check("trap_busy1", 11'b00_00_1110011);
    tick();
    TrapFlush = 1'b1;
    check("trap_flush", 11'b00_00_0001111);
    tick();
    TrapFlush = 1'b0;
    check("trap_after", 11'b00_00_0000000);

    // Redirect
    PCSrc_E = 1'b1;
    check("redirect", 11'b00_00_0001100);
    tick();
    McStart_E = 1'b1;
    check("redir_mc", 11'b00_00_0001100);
    tick();
    PCSrc_E = 1'b0; McStart_E = 1'b0;
    check("redir_mc_idle", 11'b00_00_0000000);

    // Reset in the middle of BUSY
    McStart_E = 1'b1;
    check("rst_start", 11'b00_00_1110010);
    tick();
    McStart_E = 1'b0;
    check("rst_busy", 11'b00_00_1110011);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    check("rst_mid_busy", 11'b00_00_0000000);
`ifdef HAZARD_PERF_EN
    tests_run++;
    assert (PerfMcStall === 32'd0)
    else begin
      tests_failed++;
      $error("FAIL perf_mid_rst observed=%0d expected=0", PerfMcStall);
    end
`endif

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
